// File: rtl/w5300_int_service.sv
// W5300 interrupt service sequencer: reads IR, then reads and write-1-to-clears
// Sn_IR for every enabled, flagged socket, reporting each read as an event.
module w5300_int_service #(
    parameter logic [7:0] SOCKET_MASK     = 8'h01,
    parameter int         INT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_n,
    output logic [5:0]  lut_index,
    input  logic [26:0] lut_rd_word,
    input  logic [26:0] lut_wr_word,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [26:0] cmd_data,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_data,
    output logic        evt_valid,
    output logic [3:0]  evt_src,
    output logic [15:0] evt_flags,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, IR_RD, IR_WAIT, IR_WR, IR_WACK, SCAN,
        SN_RD, SN_WAIT, SN_WR, SN_WACK, DONE
    } state_t;

    state_t                     state;
    logic [INT_SYNC_STAGES-1:0] sync_q;
    logic                       int_low;
    logic [15:0]                ir;
    logic [15:0]                sf;
    logic [2:0]                 n;
    logic                       resume;
    logic                       lut_wr_unused;

    // Chain resets to 1 so a released reset never looks like a pending interrupt.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[INT_SYNC_STAGES-2:0], int_n};
    end

    assign int_low       = ~sync_q[INT_SYNC_STAGES-1];
    assign busy          = (state != IDLE);
    assign lut_wr_unused = ^lut_wr_word[15:0];
    assign resume        = rsp_valid && ((state == SN_WAIT && rsp_data == 16'h0000) || state == SN_WACK);

    // The command word comes straight from registered state and the combinational LUT,
    // so it holds steady for as long as the bus engine stalls.
    // NOTE: default assignment first so no path through always_comb infers a latch.
    always_comb begin
        cmd_data = '0;
        if (cmd_valid) begin
            case (state)
                IR_RD, SN_RD: cmd_data = lut_rd_word;
                IR_WR:        cmd_data = {lut_wr_word[26:16], ir[15:8], 8'h00};
                SN_WR:        cmd_data = {lut_wr_word[26:16], sf};
                default:      cmd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ir        <= '0;
            sf        <= '0;
            n         <= '0;
            lut_index <= '0;
            cmd_valid <= 1'b0;
            evt_valid <= 1'b0;
            evt_src   <= '0;
            evt_flags <= '0;
        end else begin
            evt_valid <= 1'b0;
            case (state)
                IDLE: if (int_low) begin
                    lut_index <= '0;
                    cmd_valid <= 1'b1;
                    state     <= IR_RD;
                end
                IR_RD: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= IR_WAIT;
                end
                IR_WAIT: if (rsp_valid) begin
                    ir        <= rsp_data;
                    evt_valid <= 1'b1;
                    evt_src   <= 4'd0;
                    evt_flags <= rsp_data;
                    n         <= '0;
                    if (rsp_data[15:8] != 8'h00) begin
                        cmd_valid <= 1'b1;
                        state     <= IR_WR;
                    end else begin
                        state <= SCAN;
                    end
                end
                IR_WR: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= IR_WACK;
                end
                IR_WACK: if (rsp_valid) begin
                    n     <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    if (ir[n] && SOCKET_MASK[n]) begin
                        lut_index <= {3'b000, n} + 6'd1;
                        cmd_valid <= 1'b1;
                        state     <= SN_RD;
                    end else if (n == 3'd7) begin
                        state <= DONE;
                    end else begin
                        n <= n + 3'd1;
                    end
                end
                SN_RD: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= SN_WAIT;
                end
                SN_WAIT: if (rsp_valid) begin
                    sf        <= rsp_data;
                    evt_valid <= 1'b1;
                    evt_src   <= {1'b0, n} + 4'd1;
                    evt_flags <= rsp_data;
                    if (rsp_data != 16'h0000) begin
                        cmd_valid <= 1'b1;
                        state     <= SN_WR;
                    end
                end
                SN_WR: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= SN_WACK;
                end
                SN_WACK: ;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Socket finished (read-only or read+clear): move on to the next candidate.
            if (resume) begin
                lut_index <= '0;
                if (n == 3'd7) begin
                    state <= DONE;
                end else begin
                    n     <= n + 3'd1;
                    state <= SCAN;
                end
            end
        end
    end

endmodule

// File: tb/tb_w5300_int_service.sv
// Directed bench for w5300_int_service: a small bus-engine responder and LUT model
// drive each scenario; every task compares observations against hand-computed values.
module tb_w5300_int_service;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int_n;
    logic [5:0]  lut_index;
    logic [26:0] lut_rd_word;
    logic [26:0] lut_wr_word;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [26:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        evt_valid;
    logic [3:0]  evt_src;
    logic [15:0] evt_flags;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [26:0] IR_READ  = {1'b1, 10'h002, 16'hffff};
    localparam logic [26:0] S0_READ  = {1'b1, 10'h206, 16'hffff};

    w5300_int_service #(.SOCKET_MASK(8'h01), .INT_SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .int_n(int_n),
        .lut_index(lut_index), .lut_rd_word(lut_rd_word), .lut_wr_word(lut_wr_word),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .evt_valid(evt_valid), .evt_src(evt_src), .evt_flags(evt_flags),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // LUT model: index 0 is IR (0x002), index 1 is S0_IR (0x206).
    always_comb begin
        case (lut_index)
            6'd0:    begin lut_rd_word = {1'b1, 10'h002, 16'hffff}; lut_wr_word = {1'b0, 10'h002, 16'hffff}; end
            6'd1:    begin lut_rd_word = {1'b1, 10'h206, 16'hffff}; lut_wr_word = {1'b0, 10'h206, 16'hffff}; end
            default: begin lut_rd_word = {1'b1, 10'h3ff, 16'hffff}; lut_wr_word = {1'b0, 10'h3ff, 16'hffff}; end
        endcase
    end

    // Bus engine: wait for a command, optionally stall, accept, then answer next cycle.
    task automatic bus_op(input logic [15:0] rdata, input int stall,
                          output logic got, output logic [26:0] cmd, output logic stable,
                          output logic ev_v, output logic [3:0] ev_src, output logic [15:0] ev_flags);
        got = 1'b0; cmd = '0; stable = 1'b1; ev_v = 1'b0; ev_src = '0; ev_flags = '0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = cmd_valid;
        end
        if (got) begin
            cmd = cmd_data;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (cmd_valid !== 1'b1 || cmd_data !== cmd) stable = 1'b0;
            end
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            rsp_valid = 1'b1;
            rsp_data  = rdata;
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_data  = '0;
            ev_v = evt_valid; ev_src = evt_src; ev_flags = evt_flags;
        end
    endtask

    // Counts cycles until busy drops, noting any command issued meanwhile.
    task automatic wait_idle(output int cycles, output logic saw_cmd);
        cycles = 0; saw_cmd = 1'b0;
        while (cycles < 64) begin
            @(negedge clk);
            cycles++;
            if (cmd_valid) saw_cmd = 1'b1;
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; int_n = 1'b1; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cmd_valid, cmd_data, lut_index, evt_valid, evt_src, evt_flags, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: cv=%b cd=%h idx=%h ev=%b src=%h fl=%h busy=%b want all zero",
                     cmd_valid, cmd_data, lut_index, evt_valid, evt_src, evt_flags, busy);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b cv=%b want 0 0", busy, cmd_valid);
        end
    endtask

    task automatic test_basic();
        logic got, stable, ev_v, saw;
        logic [26:0] cmd;
        logic [3:0] src;
        logic [15:0] fl;
        int lat, cyc;
        int_n = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (cmd_valid) break;
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL startup_latency: cmd_valid after %0d edges want 3", lat);
        end
        bus_op(16'h0001, 0, got, cmd, stable, ev_v, src, fl);
        int_n = 1'b1;
        vectors++;
        if (got !== 1'b1 || cmd !== IR_READ) begin
            miscompares++;
            $display("FAIL basic_ir_cmd: got=%b cmd=%h want %h", got, cmd, IR_READ);
        end
        vectors++;
        if ({ev_v, src, fl} !== {1'b1, 4'd0, 16'h0001}) begin
            miscompares++;
            $display("FAIL basic_ir_evt: v=%b src=%h fl=%h want 1 0 0001", ev_v, src, fl);
        end
        @(negedge clk);
        vectors++;
        if (evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL evt_one_cycle: evt_valid=%b want 0", evt_valid);
        end
        bus_op(16'h0004, 0, got, cmd, stable, ev_v, src, fl);
        vectors++;
        if (got !== 1'b1 || cmd !== S0_READ) begin
            miscompares++;
            $display("FAIL basic_s0_cmd: got=%b cmd=%h want %h", got, cmd, S0_READ);
        end
        vectors++;
        if ({ev_v, src, fl} !== {1'b1, 4'd1, 16'h0004}) begin
            miscompares++;
            $display("FAIL basic_s0_evt: v=%b src=%h fl=%h want 1 1 0004", ev_v, src, fl);
        end
        bus_op(16'h0000, 0, got, cmd, stable, ev_v, src, fl);
        vectors++;
        if (got !== 1'b1 || cmd !== {1'b0, 10'h206, 16'h0004} || ev_v !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_s0_clear: got=%b cmd=%h ev=%b want 1 %h 0", got, cmd, ev_v,
                     {1'b0, 10'h206, 16'h0004});
        end
        wait_idle(cyc, saw);
        vectors++;
        if (cyc !== 8 || saw !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: idle after %0d cycles cmd=%b want 8 0", cyc, saw);
        end
    endtask

    task automatic test_ir_upper();
        logic got, stable, ev_v, saw;
        logic [26:0] cmd;
        logic [3:0] src;
        logic [15:0] fl;
        int cyc;
        int_n = 1'b0;
        bus_op(16'h8001, 0, got, cmd, stable, ev_v, src, fl);
        int_n = 1'b1;
        vectors++;
        if ({got, ev_v, src, fl} !== {1'b1, 1'b1, 4'd0, 16'h8001}) begin
            miscompares++;
            $display("FAIL upper_ir_evt: got=%b v=%b src=%h fl=%h want 1 1 0 8001", got, ev_v, src, fl);
        end
        bus_op(16'h0000, 0, got, cmd, stable, ev_v, src, fl);
        vectors++;
        if (got !== 1'b1 || cmd !== {1'b0, 10'h002, 16'h8000} || ev_v !== 1'b0) begin
            miscompares++;
            $display("FAIL upper_ir_write: got=%b cmd=%h ev=%b want 1 %h 0", got, cmd, ev_v,
                     {1'b0, 10'h002, 16'h8000});
        end
        bus_op(16'h0000, 0, got, cmd, stable, ev_v, src, fl);
        vectors++;
        if (got !== 1'b1 || cmd !== S0_READ || {ev_v, src, fl} !== {1'b1, 4'd1, 16'h0000}) begin
            miscompares++;
            $display("FAIL upper_s0_read: got=%b cmd=%h v=%b src=%h fl=%h want 1 %h 1 1 0000",
                     got, cmd, ev_v, src, fl, S0_READ);
        end
        wait_idle(cyc, saw);
        vectors++;
        if (cyc !== 8 || saw !== 1'b0) begin
            miscompares++;
            $display("FAIL upper_no_s0_write: idle after %0d cycles cmd=%b want 8 0", cyc, saw);
        end
    endtask

    task automatic test_scan_mask();
        logic got, stable, ev_v, saw;
        logic [26:0] cmd;
        logic [3:0] src;
        logic [15:0] fl;
        int cyc;
        int_n = 1'b0;
        bus_op(16'h00ff, 0, got, cmd, stable, ev_v, src, fl);
        int_n = 1'b1;
        bus_op(16'h0000, 0, got, cmd, stable, ev_v, src, fl);
        vectors++;
        if (got !== 1'b1 || cmd !== S0_READ || {ev_v, src} !== {1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL mask_s0_read: got=%b cmd=%h v=%b src=%h want 1 %h 1 1", got, cmd, ev_v, src, S0_READ);
        end
        wait_idle(cyc, saw);
        vectors++;
        if (cyc !== 8 || saw !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_scan_len: idle after %0d cycles cmd=%b want 8 0", cyc, saw);
        end
    endtask

    task automatic test_stall();
        logic got, stable, ev_v, saw;
        logic [26:0] cmd;
        logic [3:0] src;
        logic [15:0] fl;
        int cyc;
        int_n = 1'b0;
        bus_op(16'h0001, 0, got, cmd, stable, ev_v, src, fl);
        int_n = 1'b1;
        bus_op(16'h0004, 0, got, cmd, stable, ev_v, src, fl);
        bus_op(16'h0000, 5, got, cmd, stable, ev_v, src, fl);
        vectors++;
        if (got !== 1'b1 || stable !== 1'b1 || cmd !== {1'b0, 10'h206, 16'h0004}) begin
            miscompares++;
            $display("FAIL stall_hold: got=%b stable=%b cmd=%h want 1 1 %h", got, stable, cmd,
                     {1'b0, 10'h206, 16'h0004});
        end
        wait_idle(cyc, saw);
    endtask

    task automatic test_back_to_back();
        logic got, stable, ev_v, saw;
        logic [26:0] cmd;
        logic [3:0] src;
        logic [15:0] fl;
        int c, idle_at, cyc;
        int_n = 1'b0;
        bus_op(16'h0000, 0, got, cmd, stable, ev_v, src, fl);
        c = 0; idle_at = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            if (!busy && idle_at == 0) idle_at = c;
            if (cmd_valid) break;
        end
        int_n = 1'b1;
        vectors++;
        if (c !== 10 || idle_at !== 9 || cmd_data !== IR_READ) begin
            miscompares++;
            $display("FAIL retrigger: cmd at %0d idle at %0d cmd=%h want 10 9 %h", c, idle_at, cmd_data, IR_READ);
        end
        bus_op(16'h0000, 0, got, cmd, stable, ev_v, src, fl);
        wait_idle(cyc, saw);
        vectors++;
        if (cyc !== 9 || saw !== 1'b0) begin
            miscompares++;
            $display("FAIL retrigger_end: idle after %0d cycles cmd=%b want 9 0", cyc, saw);
        end
    endtask

    task automatic test_reset_midop();
        logic got, stable, ev_v;
        logic [26:0] cmd;
        logic [3:0] src;
        logic [15:0] fl;
        int_n = 1'b0;
        bus_op(16'h0001, 0, got, cmd, stable, ev_v, src, fl);
        int_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cmd_valid;
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (got !== 1'b1 || busy !== 1'b1 || lut_index !== 6'd1) begin
            miscompares++;
            $display("FAIL midop_reach_wait: got=%b busy=%b idx=%h want 1 1 01", got, busy, lut_index);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cmd_valid, cmd_data, lut_index, evt_valid, evt_src, evt_flags, busy} !== '0) begin
            miscompares++;
            $display("FAIL midop_reset: cv=%b cd=%h idx=%h ev=%b src=%h fl=%h busy=%b want all zero",
                     cmd_valid, cmd_data, lut_index, evt_valid, evt_src, evt_flags, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = 16'h0004;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = '0;
        vectors++;
        if (evt_valid !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_rsp: ev=%b busy=%b cv=%b want 0 0 0", evt_valid, busy, cmd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ir_upper();
        test_scan_mask();
        test_stall();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
